// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
// Shared types and helpers for the load/store stage:
//   - mem_op_t     : operation class presented by the core
//   - mem_state_t  : load/store FSM states
//   - F3_*         : RISC-V funct3 encodings for loads and stores
//   - access_ok    : funct3/alignment legality check
//   - store_strb   : byte-enable lanes for a store
//   - store_wdata  : store data replicated into byte lanes
// -----------------------------------------------------------------------------
package mem_access_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_RESP = 2'd2,
    ST_DONE      = 2'd3
  } mem_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Legal means a supported funct3 for the operation and a naturally aligned
  // address. Unsupported encodings are reported exactly like misalignment.
  function automatic logic access_ok(input logic       is_store,
                                     input logic [2:0] funct3,
                                     input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    if (is_store) begin
      case (funct3)
        F3_SB:   ok = 1'b1;
        F3_SH:   ok = ~off[0];
        F3_SW:   ok = (off == 2'b00);
        default: ok = 1'b0;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LBU: ok = 1'b1;
        F3_LH, F3_LHU: ok = ~off[0];
        F3_LW:         ok = (off == 2'b00);
        default:       ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // Byte enables for a store; only called for legal stores.
  function automatic logic [3:0] store_strb(input logic [2:0] funct3,
                                            input logic [1:0] off);
    logic [3:0] s;
    s = 4'b0000;
    case (funct3)
      F3_SB:   s = 4'b0001 << off;
      F3_SH:   s = off[1] ? 4'b1100 : 4'b0011;
      F3_SW:   s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  // Replicate the store operand so every enabled lane carries the right byte.
  function automatic logic [31:0] store_wdata(input logic [2:0]  funct3,
                                              input logic [31:0] data);
    logic [31:0] w;
    w = data;
    case (funct3)
      F3_SB:   w = {4{data[7:0]}};
      F3_SH:   w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Combinational load formatter: picks the addressed byte/half out of a raw
// 32-bit bus word, sign- or zero-extends it and produces the write-back mask.
// Ports:
//   raw    in  32  raw word from the data bus
//   offset in  2   address bits [1:0] of the access
//   funct3 in  3   load funct3 (LB, LH, LW, LBU, LHU)
//   data   out 32  extended load value
//   mask   out 32  write-back mask (FFFFFFFF, 0000FFFF or 000000FF)
// -----------------------------------------------------------------------------
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data,
  output logic [31:0] mask
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection followed by extension according to funct3.
  always_comb begin
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    data     = 32'h0000_0000;
    mask     = 32'h0000_0000;

    case (offset)
      2'b00:   byte_sel = raw[7:0];
      2'b01:   byte_sel = raw[15:8];
      2'b10:   byte_sel = raw[23:16];
      2'b11:   byte_sel = raw[31:24];
      default: byte_sel = 8'h00;
    endcase

    if (offset[1]) begin
      half_sel = raw[31:16];
    end else begin
      half_sel = raw[15:0];
    end

    case (funct3)
      F3_LB: begin
        data = {{24{byte_sel[7]}}, byte_sel};
        mask = 32'hFFFF_FFFF;
      end
      F3_LH: begin
        data = {{16{half_sel[15]}}, half_sel};
        mask = 32'hFFFF_FFFF;
      end
      F3_LW: begin
        data = raw;
        mask = 32'hFFFF_FFFF;
      end
      F3_LBU: begin
        data = {24'h00_0000, byte_sel};
        mask = 32'h0000_00FF;
      end
      F3_LHU: begin
        data = {16'h0000, half_sel};
        mask = 32'h0000_FFFF;
      end
      default: begin
        data = 32'h0000_0000;
        mask = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
// Load/store stage between execute and write-back. Issues one valid/ready
// request per access to data memory, waits for the load response (bounded by
// TIMEOUT_CYCLES) and hands write-back an aligned, extended value plus mask.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   mem_op            MEM_NONE / MEM_LOAD / MEM_STORE (mem_op_t encoding)
//   mem_funct3        RISC-V load/store funct3
//   addr, store_data  effective address and rs2 value from execute
//   dreq_*            request channel (valid/ready, word address, we, lanes)
//   dresp_valid/data  load response channel
//   read_data/valid   extended load value and its 1-cycle strobe
//   wb_mask           write-back mask matching read_data
//   mem_busy          stall request while an access is outstanding
//   misaligned        1-cycle strobe: misaligned or unsupported access
//   bus_error         1-cycle strobe: load response timed out
// -----------------------------------------------------------------------------
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mem_op,
  input  logic [2:0]            mem_funct3,
  input  logic [31:0]           addr,
  input  logic [31:0]           store_data,
  output logic                  dreq_valid,
  input  logic                  dreq_ready,
  output logic [ADDR_WIDTH-1:0] dreq_addr,
  output logic                  dreq_we,
  output logic [31:0]           dreq_wdata,
  output logic [3:0]            dreq_strb,
  input  logic                  dresp_valid,
  input  logic [31:0]           dresp_data,
  output logic [31:0]           read_data,
  output logic                  read_valid,
  output logic [31:0]           wb_mask,
  output logic                  mem_busy,
  output logic                  misaligned,
  output logic                  bus_error
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             is_load;
  logic [1:0]       off_r;
  logic [2:0]       f3_r;
  // Set while the presented op is illegal so a held bad instruction
  // reports misaligned once rather than every cycle.
  logic             exc_hold;

  logic             op_active;
  logic             op_store;
  logic             op_ok;
  logic             start;
  logic [31:0]      align_data;
  logic [31:0]      align_mask;

  // Decode the presented operation and decide whether IDLE may launch it.
  always_comb begin
    op_active = (mem_op == MEM_LOAD) || (mem_op == MEM_STORE);
    op_store  = (mem_op == MEM_STORE);
    op_ok     = access_ok(op_store, mem_funct3, addr[1:0]);
    if (state == ST_IDLE) begin
      start = op_active & op_ok;
    end else begin
      start = 1'b0;
    end
  end

  // Stall is combinational in IDLE so fetch holds in the very cycle a
  // legal access is first presented; otherwise it follows the state.
  always_comb begin
    if (!rst_n) begin
      mem_busy = 1'b0;
    end else if ((state == ST_REQ) || (state == ST_WAIT_RESP)) begin
      mem_busy = 1'b1;
    end else begin
      mem_busy = start;
    end
  end

  // Offset and funct3 are captured at REQ entry, so the response is
  // formatted for the access that was issued, not what the core shows now.
  load_align u_load_align (
    .raw    (dresp_data),
    .offset (off_r),
    .funct3 (f3_r),
    .data   (align_data),
    .mask   (align_mask)
  );

  // Load/store FSM with timeout counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= {CNT_W{1'b0}};
      is_load    <= 1'b0;
      off_r      <= 2'b00;
      f3_r       <= 3'b000;
      exc_hold   <= 1'b0;
      dreq_valid <= 1'b0;
      dreq_addr  <= {ADDR_WIDTH{1'b0}};
      dreq_we    <= 1'b0;
      dreq_wdata <= 32'h0000_0000;
      dreq_strb  <= 4'b0000;
      read_data  <= 32'h0000_0000;
      read_valid <= 1'b0;
      wb_mask    <= 32'h0000_0000;
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      read_valid <= 1'b0;
      misaligned <= 1'b0;
      bus_error  <= 1'b0;

      case (state)
        ST_IDLE: begin
          exc_hold <= op_active & ~op_ok;
          if (start) begin
            state      <= ST_REQ;
            dreq_valid <= 1'b1;
            dreq_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
            dreq_we    <= op_store;
            dreq_wdata <= op_store ? store_wdata(mem_funct3, store_data) : 32'h0000_0000;
            dreq_strb  <= op_store ? store_strb(mem_funct3, addr[1:0]) : 4'b1111;
            is_load    <= ~op_store;
            off_r      <= addr[1:0];
            f3_r       <= mem_funct3;
          end else if (op_active && !op_ok && !exc_hold) begin
            misaligned <= 1'b1;
          end
        end

        ST_REQ: begin
          if (dreq_ready) begin
            dreq_valid <= 1'b0;
            cnt        <= {CNT_W{1'b0}};
            state      <= is_load ? ST_WAIT_RESP : ST_DONE;
          end
        end

        ST_WAIT_RESP: begin
          cnt <= cnt + CNT_W'(1);
          // A response in the timeout cycle still wins over the error.
          if (dresp_valid) begin
            read_data  <= align_data;
            wb_mask    <= align_mask;
            read_valid <= 1'b1;
            state      <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            read_data  <= 32'h0000_0000;
            wb_mask    <= align_mask;
            read_valid <= 1'b1;
            bus_error  <= 1'b1;
            state      <= ST_DONE;
          end
        end

        ST_DONE: begin
          // The core advances its PC here; the next op is sampled in IDLE.
          state <= ST_IDLE;
        end

        default: begin
          state      <= ST_IDLE;
          dreq_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
